rcv_field_shifter: RTL and testbench
====================================

// Module: rcv_field_shifter
// PURPOSE
//  USB receive field deserializer, directly upstream of the receiver control unit.
//  - Takes the decoded serial bit stream (one strobe per bit time) and removes stuffed bits.
//  - Shifts bits LSB-first into per-field registers (SYNC/PID/CRC5/DATA/CRC16).
//  - Selects the field from the control unit's *_rcving enables.
//  - Pulses *_bits_received once a field is complete.
// PARAMETERS
//  DATA_BITS    64  width of data payload field (rcv_data); legal 8..64, multiple of 8
//  STUFF_LIMIT  6   consecutive 1s after which the next bit is a stuffed 0
// PORTS
//  clk                  in   1          system clock, all logic on rising edge
//  rst                  in   1          synchronous, active-high reset
//  shift_enable         in   1          one-cycle strobe: d_orig valid this cycle
//  d_orig               in   1          NRZI-decoded bit
//  sync_rcving          in   1          field select: SYNC (8 bits)
//  pid_rcving           in   1          field select: PID (8 bits)
//  crc5_rcving          in   1          field select: CRC5 (5 bits)
//  data_rcving          in   1          field select: DATA (DATA_BITS bits)
//  crc16_rcving         in   1          field select: CRC16 (16 bits)
//  rcv_sync             out  8          SYNC field, first bit received ends in [0]
//  rcv_pid              out  8          PID field
//  rcv_crc5             out  5          CRC5 field
//  rcv_crc16            out  16         CRC16 field
//  rcv_data             out  DATA_BITS  data payload
//  sync_bits_received   out  1          1-cycle pulse: SYNC complete
//  pid_bits_received    out  1          1-cycle pulse: PID complete
//  crc5_bits_received   out  1          1-cycle pulse: CRC5 complete
//  data_bits_received   out  1          1-cycle pulse: DATA complete
//  crc16_bits_received  out  1          1-cycle pulse: CRC16 complete
//  stuff_err            out  1          sticky: stuffed-bit position carried a 1
//  crc16_ok             out  1          data+CRC16 residual check passed (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge) clears all outputs and internal state to 0:
//    field regs, bit_cnt, ones_cnt, done, prev_field, stuff_err, *_bits_received.
//  - Active field: exactly one *_rcving high. None high, or more than one high -> IDLE.
//    In IDLE: no shift, no count; bit_cnt=0, done=0.
//  - prev_field is a register. When active field != prev_field: bit_cnt and done clear.
//    If shift_enable is also high in that cycle, its bit is bit 0 of the new field.
//  - Unstuffing (applies in every non-IDLE field):
//    - ones_cnt counts consecutive accepted 1s; an accepted 0 clears it.
//    - When ones_cnt==STUFF_LIMIT, the next strobed bit is discarded (no shift, no count) and ones_cnt clears.
//    - If that discarded bit is 1: stuff_err<=1.
//    - ones_cnt clears on entry to IDLE.
//  - Accepted bit (strobe, field active, not stuffed, done=0):
//    - field_reg <= {d_orig, field_reg[W-1:1]}; bit_cnt++.
//    - Shift into field_reg is LSB-first into the MSB end, so SYNC KJKJKJKK -> rcv_sync==8'h80.
//  - Completion: the accepted bit with bit_cnt==W-1 asserts <field>_bits_received the next cycle,
//    for exactly 1 cycle; done<=1.
//  - While done=1, further strobes in the same field are ignored: no shift, no pulse.
//  - Field regs hold their value until overwritten by the next reception of that field.
//    Field exit mid-way: partial contents remain, no pulse.
//  - stuff_err clears only on rst or on the cycle sync_rcving rises (new packet).
//  - Latency: last bit strobe at edge N -> pulse high during cycle N+1; field reg already valid.
//  - Bit counter is 7 bits wide (max 64).
// CONFIGURATION
//  Macro RCV_CRC16_CHK_EN.
//  - Defined:
//    - 16-bit LFSR: poly x^16+x^15+x^2+1, init 16'hFFFF.
//    - Re-inits when data_rcving becomes the active field.
//    - Advances on every accepted DATA and CRC16 bit.
//    - On crc16_bits_received: crc16_ok <= (lfsr == 16'h800D residual).
//    - crc16_ok clears on re-init and on rst.
//  - Undefined: no LFSR logic; crc16_ok is driven constant 1'b1.
// TESTING
//  T1 rst mid-DATA after 20 bits -> all outputs 0 next cycle; bit_cnt=0.
//     Then data_rcving with 64 strobes -> single data_bits_received.
//  T2 sync_rcving, strobe 0,0,0,0,0,0,0,1 -> rcv_sync==8'h80; sync_bits_received high 1 cycle after 8th strobe.
//  T3 pid_rcving, bits of 8'hA5 LSB-first -> rcv_pid==8'hA5, one pulse.
//     9th strobe while still pid_rcving -> rcv_pid unchanged, no pulse.
//  T4 data_rcving, six 1s then stuffed 0 then 58 bits -> data pulse after 65 strobes; stuffed 0 absent from rcv_data.
//     Same test with stuffed 1 -> stuff_err=1, held until next sync_rcving rise.
//  T5 crc5_rcving dropped after 3 bits, re-raised -> count restarts; pulse only after 5 further bits.
//     Two *_rcving high at once -> no shift, no pulse.
//  T6 (RCV_CRC16_CHK_EN) DATA 64'h0 plus its correct CRC16 -> crc16_ok=1; flip one CRC bit -> crc16_ok=0.
//     Build without macro -> crc16_ok=1 always.

Source files
------------

// File: rtl/rcv_field_shifter.sv
// USB receive field deserializer: unstuffs the decoded bit stream and shifts it LSB-first into per-field registers.
// Optional data+CRC16 residual check is compiled in with RCV_CRC16_CHK_EN; otherwise crc16_ok is tied high.
module rcv_field_shifter #(
  parameter int DATA_BITS   = 64,
  parameter int STUFF_LIMIT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_enable,
  input  logic                 d_orig,
  input  logic                 sync_rcving,
  input  logic                 pid_rcving,
  input  logic                 crc5_rcving,
  input  logic                 data_rcving,
  input  logic                 crc16_rcving,
  output logic [7:0]           rcv_sync,
  output logic [7:0]           rcv_pid,
  output logic [4:0]           rcv_crc5,
  output logic [15:0]          rcv_crc16,
  output logic [DATA_BITS-1:0] rcv_data,
  output logic                 sync_bits_received,
  output logic                 pid_bits_received,
  output logic                 crc5_bits_received,
  output logic                 data_bits_received,
  output logic                 crc16_bits_received,
  output logic                 stuff_err,
  output logic                 crc16_ok
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);

  typedef enum logic [2:0] {F_IDLE, F_SYNC, F_PID, F_CRC5, F_DATA, F_CRC16} field_e;

  field_e        cur_field, prev_field;
  logic [6:0]    bit_cnt, cnt_base, last_idx;
  logic [OW-1:0] ones_cnt;
  logic          done, done_base, changed, active, stuffed, accept, complete;
  logic          sync_q;

  always_comb begin
    cur_field = F_IDLE;
    last_idx  = 7'd0;
    case ({sync_rcving, pid_rcving, crc5_rcving, data_rcving, crc16_rcving})
      5'b10000: cur_field = F_SYNC;
      5'b01000: cur_field = F_PID;
      5'b00100: cur_field = F_CRC5;
      5'b00010: cur_field = F_DATA;
      5'b00001: cur_field = F_CRC16;
      default:  cur_field = F_IDLE;
    endcase
    case (cur_field)
      F_SYNC:  last_idx = 7'd7;
      F_PID:   last_idx = 7'd7;
      F_CRC5:  last_idx = 7'd4;
      F_DATA:  last_idx = 7'(DATA_BITS - 1);
      F_CRC16: last_idx = 7'd15;
      default: last_idx = 7'd0;
    endcase
    // A field switch restarts counting; a bit strobed in that same cycle is bit 0.
    changed   = (cur_field != prev_field);
    cnt_base  = changed ? 7'd0 : bit_cnt;
    done_base = changed ? 1'b0 : done;
    active    = (cur_field != F_IDLE);
    stuffed   = shift_enable && active && (ones_cnt == OW'(STUFF_LIMIT));
    accept    = shift_enable && active && !stuffed && !done_base;
    complete  = accept && (cnt_base == last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_field          <= F_IDLE;
      bit_cnt             <= '0;
      ones_cnt            <= '0;
      done                <= 1'b0;
      sync_q              <= 1'b0;
      rcv_sync            <= '0;
      rcv_pid             <= '0;
      rcv_crc5            <= '0;
      rcv_crc16           <= '0;
      rcv_data            <= '0;
      sync_bits_received  <= 1'b0;
      pid_bits_received   <= 1'b0;
      crc5_bits_received  <= 1'b0;
      data_bits_received  <= 1'b0;
      crc16_bits_received <= 1'b0;
      stuff_err           <= 1'b0;
    end else begin
      prev_field          <= cur_field;
      sync_q              <= sync_rcving;
      sync_bits_received  <= complete && (cur_field == F_SYNC);
      pid_bits_received   <= complete && (cur_field == F_PID);
      crc5_bits_received  <= complete && (cur_field == F_CRC5);
      data_bits_received  <= complete && (cur_field == F_DATA);
      crc16_bits_received <= complete && (cur_field == F_CRC16);

      if (!active) begin
        bit_cnt  <= '0;
        done     <= 1'b0;
        ones_cnt <= '0;
      end else begin
        bit_cnt <= accept ? cnt_base + 7'd1 : cnt_base;
        done    <= done_base || complete;
        if (stuffed)
          ones_cnt <= '0;
        else if (accept)
          ones_cnt <= d_orig ? ones_cnt + OW'(1) : '0;
      end

      if (accept) begin
        case (cur_field)
          F_SYNC:  rcv_sync  <= {d_orig, rcv_sync[7:1]};
          F_PID:   rcv_pid   <= {d_orig, rcv_pid[7:1]};
          F_CRC5:  rcv_crc5  <= {d_orig, rcv_crc5[4:1]};
          F_DATA:  rcv_data  <= {d_orig, rcv_data[DATA_BITS-1:1]};
          F_CRC16: rcv_crc16 <= {d_orig, rcv_crc16[15:1]};
          default: ;
        endcase
      end

      // A new packet clears the sticky error; a stuff violation in that same cycle still sets it.
      if (sync_rcving && !sync_q)
        stuff_err <= 1'b0;
      if (stuffed && d_orig)
        stuff_err <= 1'b1;
    end
  end

`ifdef RCV_CRC16_CHK_EN
  logic [15:0] lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((b ^ s[15]) ? 16'h8005 : 16'h0000);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= 16'hFFFF;
      crc16_ok <= 1'b0;
    end else begin
      if (crc16_bits_received)
        crc16_ok <= (lfsr == 16'h800D);
      if (cur_field == F_DATA && changed) begin
        lfsr     <= accept ? lfsr_step(16'hFFFF, d_orig) : 16'hFFFF;
        crc16_ok <= 1'b0;
      end else if (accept && (cur_field == F_DATA || cur_field == F_CRC16)) begin
        lfsr <= lfsr_step(lfsr, d_orig);
      end
    end
  end
`else
  assign crc16_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rcv_field_shifter.sv
// Bench for rcv_field_shifter: vector table, directed multi-cycle corner cases, then randomized run against a field-level model.
module tb_rcv_field_shifter;

  localparam int DW = 64;
`ifdef RCV_CRC16_CHK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          shift_enable = 1'b0, d_orig = 1'b0;
  logic          sync_rcving = 1'b0, pid_rcving = 1'b0, crc5_rcving = 1'b0;
  logic          data_rcving = 1'b0, crc16_rcving = 1'b0;
  logic [7:0]    rcv_sync, rcv_pid;
  logic [4:0]    rcv_crc5;
  logic [15:0]   rcv_crc16;
  logic [DW-1:0] rcv_data;
  logic          sync_bits_received, pid_bits_received, crc5_bits_received;
  logic          data_bits_received, crc16_bits_received, stuff_err, crc16_ok;
  logic [4:0]    pulses;

  int checks = 0;
  int errors = 0;

  rcv_field_shifter #(.DATA_BITS(DW), .STUFF_LIMIT(6)) dut (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .d_orig(d_orig),
    .sync_rcving(sync_rcving), .pid_rcving(pid_rcving), .crc5_rcving(crc5_rcving),
    .data_rcving(data_rcving), .crc16_rcving(crc16_rcving),
    .rcv_sync(rcv_sync), .rcv_pid(rcv_pid), .rcv_crc5(rcv_crc5),
    .rcv_crc16(rcv_crc16), .rcv_data(rcv_data),
    .sync_bits_received(sync_bits_received), .pid_bits_received(pid_bits_received),
    .crc5_bits_received(crc5_bits_received), .data_bits_received(data_bits_received),
    .crc16_bits_received(crc16_bits_received), .stuff_err(stuff_err), .crc16_ok(crc16_ok)
  );

  always #5 clk = ~clk;

  assign pulses = {sync_bits_received, pid_bits_received, crc5_bits_received,
                   data_bits_received, crc16_bits_received};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [4:0] s);
    {sync_rcving, pid_rcving, crc5_rcving, data_rcving, crc16_rcving} = s;
  endtask

  task automatic idle(input int n);
    set_sel(5'b0);
    shift_enable = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic b);
    shift_enable = 1'b1;
    d_orig = b;
    tick();
    shift_enable = 1'b0;
    d_orig = 1'b0;
  endtask

  function automatic logic [63:0] field_out(input logic [4:0] s);
    case (s)
      5'b10000: return 64'(rcv_sync);
      5'b01000: return 64'(rcv_pid);
      5'b00100: return 64'(rcv_crc5);
      5'b00010: return 64'(rcv_data);
      default:  return 64'(rcv_crc16);
    endcase
  endfunction

  typedef struct {
    logic [4:0]  sel;
    int          nbits;
    logic [63:0] pat;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [7];

  // Field-level reference model state (index 1..5 = sync, pid, crc5, data, crc16).
  int          m_prev, m_cnt, m_ones;
  logic        m_done, m_err, m_sync_q;
  logic [63:0] m_reg [6];
  logic [4:0]  m_pulse;
  int          m_w [6] = '{0, 8, 8, 5, DW, 16};

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_ones = 0; m_done = 0; m_err = 0; m_sync_q = 0; m_pulse = '0;
    for (int k = 0; k < 6; k++) m_reg[k] = '0;
  endtask

  task automatic model_step(input logic [4:0] s, input logic se, input logic b);
    int f;
    f = 0;
    if ($countones(s) == 1)
      for (int k = 0; k < 5; k++) if (s[k]) f = 5 - k;
    m_pulse = '0;
    if (f != m_prev) begin m_cnt = 0; m_done = 0; end
    if (s[4] && !m_sync_q) m_err = 0;
    if (f == 0) begin
      m_cnt = 0; m_done = 0; m_ones = 0;
    end else if (se) begin
      if (m_ones == 6) begin
        m_ones = 0;
        if (b) m_err = 1;
      end else if (!m_done) begin
        m_reg[f] = (m_reg[f] >> 1) | (64'(b) << (m_w[f] - 1));
        m_cnt++;
        m_ones = b ? m_ones + 1 : 0;
        if (m_cnt == m_w[f]) begin m_done = 1; m_pulse = s; end
      end
    end
    m_sync_q = s[4];
    m_prev = f;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  initial begin
    int          npulse, first_idx;
    logic [7:0]  sv_sync, sv_pid;
    logic [4:0]  rs;
    logic        rb, rse;
    logic [15:0] crc, sent;
    int          tb_ones;

    tbl[0] = '{5'b10000, 8,  64'h80, 64'h80};
    tbl[1] = '{5'b01000, 8,  64'hA5, 64'hA5};
    tbl[2] = '{5'b00100, 5,  64'h15, 64'h15};
    tbl[3] = '{5'b00001, 16, 64'h1234, 64'h1234};
    tbl[4] = '{5'b00010, 64, 64'h5A5A_1234_A5A5_C3C3, 64'h5A5A_1234_A5A5_C3C3};
    tbl[5] = '{5'b00100, 5,  64'h0A, 64'h0A};
    tbl[6] = '{5'b10000, 8,  64'h3C, 64'h3C};

    // Reset state
    tick(); tick();
    check("rst_fields", {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16}, 64'h0);
    check("rst_data", rcv_data, 64'h0);
    check("rst_flags", {pulses, stuff_err}, 64'h0);
    check("rst_crc16_ok", 64'(crc16_ok), 64'(!CRC_EN));
    rst = 1'b0;
    idle(2);

    // Vector table: field selected and first bit strobed in the same cycle
    foreach (tbl[v]) begin
      idle(1);
      set_sel(tbl[v].sel);
      for (int i = 0; i < tbl[v].nbits; i++) begin
        logic [63:0] p;
        p = tbl[v].pat;
        strobe(p[i]);
        check($sformatf("tbl%0d_pulse_b%0d", v, i), 64'(pulses),
              (i == tbl[v].nbits - 1) ? 64'(tbl[v].sel) : 64'h0);
      end
      check($sformatf("tbl%0d_value", v), field_out(tbl[v].sel), tbl[v].exp);
      tick();
      check($sformatf("tbl%0d_pulse_gone", v), 64'(pulses), 64'h0);
    end

    // T1: reset mid-DATA, then a full DATA reception
    idle(1);
    set_sel(5'b00010);
    for (int i = 0; i < 20; i++) strobe(i[0]);
    rst = 1'b1; shift_enable = 1'b1; d_orig = 1'b1;
    tick();
    rst = 1'b0; shift_enable = 1'b0;
    check("t1_rst_data", rcv_data, 64'h0);
    check("t1_rst_flags", {pulses, stuff_err}, 64'h0);
    check("t1_rst_fields", {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16}, 64'h0);
    npulse = 0;
    for (int i = 0; i < 64; i++) begin
      strobe(i[0]);
      npulse += int'(data_bits_received);
    end
    check("t1_pulse_at_64", 64'(data_bits_received), 64'h1);
    for (int i = 0; i < 3; i++) begin tick(); npulse += int'(data_bits_received); end
    check("t1_pulse_count", 64'(npulse), 64'd1);
    check("t1_data", rcv_data, 64'hAAAA_AAAA_AAAA_AAAA);

    // T3: ninth PID strobe is ignored
    idle(1);
    set_sel(5'b01000);
    for (int i = 0; i < 8; i++) strobe(i == 0 || i == 2 || i == 5 || i == 7);
    check("t3_pid", 64'(rcv_pid), 64'hA5);
    strobe(1'b0);
    check("t3_9th_no_pulse", 64'(pulses), 64'h0);
    check("t3_9th_pid_held", 64'(rcv_pid), 64'hA5);

    // T4: stuffed bit after six 1s (clean 0, then a violating 1)
    for (int pass = 0; pass < 2; pass++) begin
      idle(1);
      set_sel(5'b00010);
      npulse = 0; first_idx = -1;
      for (int i = 0; i < 65; i++) begin
        strobe((i < 6) || (i == 6 && pass == 1));
        if (data_bits_received) begin
          npulse++;
          if (first_idx < 0) first_idx = i;
        end
      end
      tick();
      npulse += int'(data_bits_received);
      check($sformatf("t4_p%0d_pulse_idx", pass), 64'(first_idx), 64'd64);
      check($sformatf("t4_p%0d_pulse_count", pass), 64'(npulse), 64'd1);
      check($sformatf("t4_p%0d_data", pass), rcv_data, 64'h3F);
      check($sformatf("t4_p%0d_stuff_err", pass), 64'(stuff_err), 64'(pass));
    end
    set_sel(5'b01000);
    for (int i = 0; i < 4; i++) strobe(1'b0);
    idle(2);
    check("t4_err_held", 64'(stuff_err), 64'h1);
    set_sel(5'b10000);
    tick();
    check("t4_err_cleared_on_sync", 64'(stuff_err), 64'h0);

    // T5: CRC5 dropped after 3 bits restarts its count
    idle(1);
    set_sel(5'b00100);
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    idle(1);
    set_sel(5'b00100);
    for (int i = 0; i < 5; i++) begin
      strobe(i == 1 || i == 2);
      check($sformatf("t5_pulse_b%0d", i), 64'(crc5_bits_received), 64'(i == 4));
    end
    check("t5_crc5", 64'(rcv_crc5), 64'h06);
    // Two selects at once: nothing shifts
    idle(1);
    sv_sync = rcv_sync; sv_pid = rcv_pid;
    set_sel(5'b11000);
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1);
      check("t5_multi_no_pulse", 64'(pulses), 64'h0);
    end
    check("t5_multi_regs", {rcv_sync, rcv_pid}, {sv_sync, sv_pid});

    // T6: data + CRC16 residual check
    for (int pass = 0; pass < 2; pass++) begin
      idle(1);
      set_sel(5'b00010);
      crc = 16'hFFFF;
      for (int i = 0; i < 64; i++) begin
        strobe(1'b0);
        crc = crc_step(crc, 1'b0);
      end
      check($sformatf("t6_p%0d_ok_mid", pass), 64'(crc16_ok), 64'(!CRC_EN));
      sent = ~crc;
      if (pass == 1) sent[3] = ~sent[3];
      set_sel(5'b00001);
      tb_ones = 0;
      for (int i = 15; i >= 0; i--) begin
        if (tb_ones == 6) begin strobe(1'b0); tb_ones = 0; end
        strobe(sent[i]);
        tb_ones = sent[i] ? tb_ones + 1 : 0;
      end
      check($sformatf("t6_p%0d_pulse", pass), 64'(crc16_bits_received), 64'h1);
      tick(); tick();
      check($sformatf("t6_p%0d_crc16_reg", pass), 64'(rcv_crc16), 64'({<<{sent}}));
      check($sformatf("t6_p%0d_crc16_ok", pass), 64'(crc16_ok), 64'(pass == 0 || !CRC_EN));
    end

    // Randomized run against the field-level model
    idle(1);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    rs = 5'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      rs = 5'b1 << (r % 5);
        else if (r == 7) rs = 5'b0;
        else if (r == 8) rs = (5'b1 << $urandom_range(0, 4)) | (5'b1 << $urandom_range(0, 4));
        else             rs = 5'($urandom_range(0, 31));
      end
      rse = ($urandom_range(0, 3) != 0);
      rb  = ($urandom_range(0, 3) != 0);
      set_sel(rs);
      shift_enable = rse;
      d_orig = rb;
      model_step(rs, rse, rb);
      tick();
      check("rnd_fields", {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16},
            {m_reg[1][7:0], m_reg[2][7:0], m_reg[3][4:0], m_reg[5][15:0]});
      check("rnd_data", rcv_data, m_reg[4]);
      check("rnd_flags", {pulses, stuff_err}, {m_pulse, m_err});
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
